// File: rtl/move_commit.sv
// ---------------------------------------------------------------------------
// move_commit
//   Accepts or rejects candidate moves of the active 2x2-box piece against the
//   fallen-block board and the board edges. A blocked down move locks the
//   piece: its cells are merged into the board, full rows are removed one row
//   per cycle (rows above shift down), and the next piece is spawned. A spawn
//   that lands on occupied cells ends the game.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   move_req                 1-cycle pulse, candidate valid (sampled in IDLE only)
//   move_is_down             candidate is a down move
//   new_pos_x/new_pos_y      candidate column / row (row 0 = top)
//   new_rot                  candidate rotation
//   piece_next               piece type taken at spawn time
//   cur_pos_x/cur_pos_y      committed position
//   cur_rot, cur_piece       committed rotation, active piece type
//   fallenBlocks             board, fallenBlocks[y][x] = 1 when occupied
//   lines_cleared            running count of removed rows (wraps)
//   busy                     1 in every state except IDLE
//   game_over                1 once the game has ended
// ---------------------------------------------------------------------------
module move_commit #(
  parameter logic [2:0] SPAWN_X = 3'd3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            move_req,
  input  logic            move_is_down,
  input  logic [2:0]      new_pos_x,
  input  logic [2:0]      new_pos_y,
  input  logic [1:0]      new_rot,
  input  logic [1:0]      piece_next,
  output logic [2:0]      cur_pos_x,
  output logic [2:0]      cur_pos_y,
  output logic [1:0]      cur_rot,
  output logic [1:0]      cur_piece,
  output logic [7:0][7:0] fallenBlocks,
  output logic [7:0]      lines_cleared,
  output logic            busy,
  output logic            game_over
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_LOCK  = 3'd2,
    S_CLEAR = 3'd3,
    S_SPAWN = 3'd4,
    S_SPCHK = 3'd5,
    S_OVER  = 3'd6
  } state_t;

  // Occupancy mask of a piece type after r clockwise rotations.
  // Bit i of the mask is the cell (dx, dy) = (i % 2, i / 2).
  function automatic logic [3:0] rot_mask(input logic [1:0] piece, input logic [1:0] rot);
    logic [3:0] m;
    case (piece)
      2'd0:    m = 4'b1111;
      2'd1:    m = 4'b0111;
      2'd2:    m = 4'b0011;
      default: m = 4'b0001;
    endcase
    for (int i = 0; i < 3; i++) begin
      if (i < int'(rot)) begin
        m = {m[1], m[3], m[0], m[2]};
      end else begin
        m = m;
      end
    end
    return m;
  endfunction

  // True when any set cell falls off the board or onto an occupied cell.
  // Coordinates are widened to 4 bits so x+1 / y+1 past column/row 7 is seen.
  function automatic logic collides(input logic [7:0][7:0] board, input logic [3:0] mask,
                                    input logic [2:0] x, input logic [2:0] y);
    logic       hit;
    logic [3:0] px;
    logic [3:0] py;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      px = {1'b0, x} + 4'(i % 2);
      py = {1'b0, y} + 4'(i / 2);
      if (mask[i]) begin
        if ((px > 4'd7) || (py > 4'd7)) begin
          hit = 1'b1;
        end else if (board[py[2:0]][px[2:0]]) begin
          hit = 1'b1;
        end else begin
          hit = hit;
        end
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

  // Board with the given piece cells ORed in (off-board cells are ignored).
  function automatic logic [7:0][7:0] place(input logic [7:0][7:0] board, input logic [3:0] mask,
                                            input logic [2:0] x, input logic [2:0] y);
    logic [7:0][7:0] b;
    logic [3:0]      px;
    logic [3:0]      py;
    b = board;
    for (int i = 0; i < 4; i++) begin
      px = {1'b0, x} + 4'(i % 2);
      py = {1'b0, y} + 4'(i / 2);
      if (mask[i] && (px <= 4'd7) && (py <= 4'd7)) begin
        b[py[2:0]][px[2:0]] = 1'b1;
      end else begin
        b = b;
      end
    end
    return b;
  endfunction

  state_t          state_q;
  logic [2:0]      pos_x_q;
  logic [2:0]      pos_y_q;
  logic [1:0]      rot_q;
  logic [1:0]      piece_q;
  logic [7:0][7:0] board_q;
  logic [7:0]      lines_q;
  logic            busy_q;
  logic            over_q;
  logic [2:0]      cand_x_q;
  logic [2:0]      cand_y_q;
  logic [1:0]      cand_rot_q;
  logic            cand_down_q;
  logic [2:0]      row_q;
  logic [3:0]      clr_cnt_q;

  logic [3:0]      cand_mask_d;
  logic [3:0]      cur_mask_d;
  logic            cand_hit_d;
  logic            cur_hit_d;
  logic [7:0][7:0] locked_board_d;
  logic [7:0][7:0] shifted_board_d;
  logic            row_full_d;

  // Collision of candidate and current piece, merged board, full-row test.
  always_comb begin
    cand_mask_d    = rot_mask(piece_q, cand_rot_q);
    cur_mask_d     = rot_mask(piece_q, rot_q);
    // A down move whose row went backwards wrapped past row 7: that is the floor.
    cand_hit_d     = collides(board_q, cand_mask_d, cand_x_q, cand_y_q) |
                     (cand_down_q & (cand_y_q < pos_y_q));
    cur_hit_d      = collides(board_q, cur_mask_d, pos_x_q, pos_y_q);
    locked_board_d = place(board_q, cur_mask_d, pos_x_q, pos_y_q);
    row_full_d     = (board_q[row_q] == 8'hFF);
  end

  // Board with row row_q removed: rows 1..row_q take the row above, row 0 empties.
  always_comb begin
    shifted_board_d    = board_q;
    shifted_board_d[0] = 8'h00;
    for (int i = 1; i < 8; i++) begin
      if (3'(i) <= row_q) begin
        shifted_board_d[i] = board_q[i - 1];
      end else begin
        shifted_board_d[i] = board_q[i];
      end
    end
  end

  // Move/lock/clear/spawn controller with all outputs held in registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pos_x_q     <= SPAWN_X;
      pos_y_q     <= 3'd0;
      rot_q       <= 2'd0;
      piece_q     <= 2'd0;
      board_q     <= '0;
      lines_q     <= 8'd0;
      busy_q      <= 1'b0;
      over_q      <= 1'b0;
      cand_x_q    <= 3'd0;
      cand_y_q    <= 3'd0;
      cand_rot_q  <= 2'd0;
      cand_down_q <= 1'b0;
      row_q       <= 3'd0;
      clr_cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (move_req) begin
            cand_x_q    <= new_pos_x;
            cand_y_q    <= new_pos_y;
            cand_rot_q  <= new_rot;
            cand_down_q <= move_is_down;
            busy_q      <= 1'b1;
            state_q     <= S_CHECK;
          end else begin
            busy_q      <= 1'b0;
          end
        end
        S_CHECK: begin
          if (!cand_hit_d) begin
            pos_x_q <= cand_x_q;
            pos_y_q <= cand_y_q;
            rot_q   <= cand_rot_q;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (cand_down_q) begin
            state_q <= S_LOCK;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_LOCK: begin
          board_q   <= locked_board_d;
          row_q     <= 3'd7;
          clr_cnt_q <= 4'd0;
          state_q   <= S_CLEAR;
        end
        S_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 4'd1;
          // The same row is re-examined after a removal since a full row may
          // have dropped into it. The cycle counter caps the scan at 16 cycles.
          if (row_full_d && (clr_cnt_q != 4'd15)) begin
            board_q <= shifted_board_d;
            lines_q <= lines_q + 8'd1;
          end else if ((row_q == 3'd0) || (clr_cnt_q == 4'd15)) begin
            state_q <= S_SPAWN;
          end else begin
            row_q   <= row_q - 3'd1;
          end
        end
        S_SPAWN: begin
          piece_q <= piece_next;
          pos_x_q <= SPAWN_X;
          pos_y_q <= 3'd0;
          rot_q   <= 2'd0;
          state_q <= S_SPCHK;
        end
        S_SPCHK: begin
          if (cur_hit_d) begin
            over_q  <= 1'b1;
            state_q <= S_OVER;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_OVER: begin
          over_q  <= 1'b1;
          busy_q  <= 1'b1;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cur_pos_x     = pos_x_q;
  assign cur_pos_y     = pos_y_q;
  assign cur_rot       = rot_q;
  assign cur_piece     = piece_q;
  assign fallenBlocks  = board_q;
  assign lines_cleared = lines_q;
  assign busy          = busy_q;
  assign game_over     = over_q;

endmodule

// File: tb/tb_move_commit.sv
module tb_move_commit;

  logic            clk;
  logic            rst;
  logic            move_req;
  logic            move_is_down;
  logic [2:0]      new_pos_x;
  logic [2:0]      new_pos_y;
  logic [1:0]      new_rot;
  logic [1:0]      piece_next;
  logic [2:0]      cur_pos_x;
  logic [2:0]      cur_pos_y;
  logic [1:0]      cur_rot;
  logic [1:0]      cur_piece;
  logic [7:0][7:0] fallenBlocks;
  logic [7:0]      lines_cleared;
  logic            busy;
  logic            game_over;

  int checks = 0;
  int errors = 0;

  move_commit #(.SPAWN_X(3'd3)) dut (
    .clk           (clk),
    .rst           (rst),
    .move_req      (move_req),
    .move_is_down  (move_is_down),
    .new_pos_x     (new_pos_x),
    .new_pos_y     (new_pos_y),
    .new_rot       (new_rot),
    .piece_next    (piece_next),
    .cur_pos_x     (cur_pos_x),
    .cur_pos_y     (cur_pos_y),
    .cur_rot       (cur_rot),
    .cur_piece     (cur_piece),
    .fallenBlocks  (fallenBlocks),
    .lines_cleared (lines_cleared),
    .busy          (busy),
    .game_over     (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse a request for one cycle; returns at the negedge of the following cycle.
  task automatic req(input logic [2:0] x, input logic [2:0] y, input logic [1:0] r, input logic down);
    @(negedge clk);
    new_pos_x    = x;
    new_pos_y    = y;
    new_rot      = r;
    move_is_down = down;
    move_req     = 1'b1;
    @(negedge clk);
    move_req     = 1'b0;
    move_is_down = 1'b0;
  endtask

  // Wait until the block is idle (or the game ended), bounded.
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy !== 1'b0) && (game_over !== 1'b1) && (n < 40)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 40) else begin
      errors++;
      $error("FAIL %s: busy still high after %0d cycles, required idle", tag, n);
    end
  endtask

  task automatic chk_pos(input string tag, input logic [2:0] x, input logic [2:0] y,
                         input logic [1:0] r, input logic [1:0] p);
    chk({tag, "_x"}, 64'(cur_pos_x), 64'(x));
    chk({tag, "_y"}, 64'(cur_pos_y), 64'(y));
    chk({tag, "_rot"}, 64'(cur_rot), 64'(r));
    chk({tag, "_piece"}, 64'(cur_piece), 64'(p));
  endtask

  task automatic chk_reset_state(input string tag);
    chk_pos(tag, 3'd3, 3'd0, 2'd0, 2'd0);
    chk({tag, "_board"}, fallenBlocks, 64'h0);
    chk({tag, "_lines"}, 64'(lines_cleared), 64'h0);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
    chk({tag, "_over"}, 64'(game_over), 64'h0);
  endtask

  // Lock-chain step: move to (x, y) and then try one row lower, both as down moves.
  task automatic drop_at(input string tag, input logic [2:0] x, input logic [2:0] y);
    req(x, y, 2'd0, 1'b1);
    wait_idle({tag, "_move"});
    req(x, y + 3'd1, 2'd0, 1'b1);
    wait_idle({tag, "_lock"});
  endtask

  initial begin
    rst          = 1'b1;
    move_req     = 1'b0;
    move_is_down = 1'b0;
    new_pos_x    = 3'd0;
    new_pos_y    = 3'd0;
    new_rot      = 2'd0;
    piece_next   = 2'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state("reset");

    // Move right on an empty board: busy for exactly one cycle, result two cycles on.
    req(3'd4, 3'd0, 2'd0, 1'b0);
    chk("t1_busy_n1", 64'(busy), 64'h1);
    chk("t1_x_n1", 64'(cur_pos_x), 64'h3);
    @(negedge clk);
    chk("t1_busy_n2", 64'(busy), 64'h0);
    chk("t1_x_n2", 64'(cur_pos_x), 64'h4);

    // Right edge: x=6 fits, x=7 would put the right column at 8.
    req(3'd5, 3'd0, 2'd0, 1'b0);
    wait_idle("t2_w5");
    req(3'd6, 3'd0, 2'd0, 1'b0);
    wait_idle("t2_w6");
    chk("t2_x6", 64'(cur_pos_x), 64'h6);
    req(3'd7, 3'd0, 2'd0, 1'b0);
    wait_idle("t2_w7");
    chk("t2_x_stays", 64'(cur_pos_x), 64'h6);
    chk("t2_board", fallenBlocks, 64'h0);

    // Build rows 6/7 from the right with 2x2 pieces.
    piece_next = 2'd0;
    drop_at("l1", 3'd6, 3'd6);
    chk("l1_board", fallenBlocks, 64'hC0C0_0000_0000_0000);
    chk_pos("l1", 3'd3, 3'd0, 2'd0, 2'd0);
    drop_at("l2", 3'd4, 3'd6);
    chk("l2_board", fallenBlocks, 64'hF0F0_0000_0000_0000);
    piece_next = 2'd3;
    drop_at("l3", 3'd2, 3'd6);
    chk("l3_board", fallenBlocks, 64'hFCFC_0000_0000_0000);
    chk("l3_piece", 64'(cur_piece), 64'h3);

    // Single-cell piece at (0,7); a down request to row 0 is the floor wrap.
    piece_next = 2'd1;
    req(3'd0, 3'd7, 2'd0, 1'b0);
    wait_idle("t3_place");
    chk("t3_placed_x", 64'(cur_pos_x), 64'h0);
    chk("t3_placed_y", 64'(cur_pos_y), 64'h7);
    req(3'd0, 3'd0, 2'd0, 1'b1);
    wait_idle("t3_lock");
    chk("t3_board", fallenBlocks, 64'hFDFC_0000_0000_0000);
    chk_pos("t3_spawn", 3'd3, 3'd0, 2'd0, 2'd1);
    chk("t3_lines", 64'(lines_cleared), 64'h0);

    // L-piece: blocked sideways move onto occupied cells is rejected.
    piece_next = 2'd0;
    req(3'd2, 3'd6, 2'd0, 1'b0);
    wait_idle("t4_rej");
    chk_pos("t4_rej", 3'd3, 3'd0, 2'd0, 2'd1);
    // Rot 1 occupies (0,0),(1,0),(1,1): at (0,6) it fills the last three holes.
    req(3'd0, 3'd5, 2'd1, 1'b0);
    wait_idle("t4_rot");
    chk_pos("t4_rot", 3'd0, 3'd5, 2'd1, 2'd1);
    req(3'd0, 3'd6, 2'd1, 1'b1);
    wait_idle("t4_down");
    chk("t4_down_y", 64'(cur_pos_y), 64'h6);
    req(3'd0, 3'd7, 2'd1, 1'b1);
    wait_idle("t4_lock");
    chk("t4_lines", 64'(lines_cleared), 64'h2);
    chk("t4_board", fallenBlocks, 64'h0);
    chk_pos("t4_spawn", 3'd3, 3'd0, 2'd0, 2'd0);

    // Stack 2x2 pieces in columns 3/4 until the spawn area is covered.
    drop_at("t5a", 3'd3, 3'd6);
    chk("t5a_board", fallenBlocks, 64'h1818_0000_0000_0000);
    drop_at("t5b", 3'd3, 3'd4);
    chk("t5b_board", fallenBlocks, 64'h1818_1818_0000_0000);
    drop_at("t5c", 3'd3, 3'd2);
    chk("t5c_board", fallenBlocks, 64'h1818_1818_1818_0000);
    chk("t5c_over", 64'(game_over), 64'h0);
    req(3'd3, 3'd1, 2'd0, 1'b1);
    wait_idle("t5_final");
    chk("t5_board", fallenBlocks, 64'h1818_1818_1818_1818);
    chk("t5_over", 64'(game_over), 64'h1);
    chk("t5_busy", 64'(busy), 64'h1);
    req(3'd5, 3'd0, 2'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("t5_frozen_x", 64'(cur_pos_x), 64'h3);
    chk("t5_frozen_board", fallenBlocks, 64'h1818_1818_1818_1818);
    chk("t5_frozen_over", 64'(game_over), 64'h1);
    chk("t5_lines", 64'(lines_cleared), 64'h2);

    // Reset out of OVER, then again in the middle of a CLEAR scan.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state("t6_after_over");
    req(3'd3, 3'd6, 2'd0, 1'b1);
    wait_idle("t6_move");
    req(3'd3, 3'd7, 2'd0, 1'b1);
    repeat (3) @(negedge clk);
    chk("t6_busy_in_clear", 64'(busy), 64'h1);
    chk("t6_board_in_clear", fallenBlocks, 64'h1818_0000_0000_0000);
    rst = 1'b1;
    #1;
    chk_reset_state("t6_async");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state("t6_released");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
